// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared constants and state encoding for the register-file write-port scheduler.
package regfile_wb_scheduler_pkg;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam logic [AW-1:0] REG_RA   = 5'd31;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of ID, WB, long-unit and register-file write-port signals around the scheduler.
interface regfile_wb_scheduler_if;
  import regfile_wb_scheduler_pkg::*;

  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [AW-1:0] id_rd;
  logic          id_long;
  logic          id_stall;

  logic          wb_we;
  logic [AW-1:0] wb_rw;
  logic [DW-1:0] wb_data;

  logic          lu_valid;
  logic [AW-1:0] lu_rw;
  logic [DW-1:0] lu_data;
  logic          lu_ready;

  logic          rf_we;
  logic [AW-1:0] rf_rw;
  logic [DW-1:0] rf_busw;
  logic          init_done;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_long,
    output wb_we, wb_rw, wb_data,
    output lu_valid, lu_rw, lu_data,
    input  id_stall, lu_ready, rf_we, rf_rw, rf_busw, init_done
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_long,
    input  wb_we, wb_rw, wb_data,
    input  lu_valid, lu_rw, lu_data,
    output id_stall, lu_ready, rf_we, rf_rw, rf_busw, init_done
  );
endinterface

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Busy vector for destinations owed by the long-latency unit, with hazard lookup.
module regfile_scoreboard
  import regfile_wb_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_rs,
  input  logic [AW-1:0] i_rt,
  input  logic [AW-1:0] i_rd,
  output logic          o_rs_busy,
  output logic          o_rt_busy,
  output logic          o_rd_busy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_hit;
  logic [NREG-1:0] w_clr_hit;

  // Register 0 never becomes busy, so its hit lines are tied low.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_hit
      if (gi == 0) begin : g_zero
        assign w_set_hit[gi] = 1'b0;
        assign w_clr_hit[gi] = 1'b0;
      end else begin : g_reg
        assign w_set_hit[gi] = i_set_en && (i_set_addr == AW'(gi));
        assign w_clr_hit[gi] = i_clr_en && (i_clr_addr == AW'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_hit) | w_set_hit;
    end
  end

  assign o_rs_busy = r_busy[i_rs];
  assign o_rt_busy = r_busy[i_rt];
  assign o_rd_busy = r_busy[i_rd];
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-port controller: post-reset clear sweep, WB/long-unit arbitration,
// starvation throttling and RAW/WAW issue stalls.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wb_scheduler_if.slave bus
);
  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_clr_cnt_next;
  logic [3:0]    r_starve_cnt;

  logic w_rs_busy;
  logic w_rt_busy;
  logic w_rd_busy;
  logic w_xfer;
  logic w_issue;
  logic w_starved;
  logic w_hazard;

  assign w_xfer    = bus.lu_valid && bus.lu_ready;
  assign w_issue   = bus.id_valid && !bus.id_stall && bus.id_long && (bus.id_rd != REG_ZERO);
  assign w_starved = (r_starve_cnt >= 4'(STARVE_MAX));
  assign w_hazard  = (bus.id_use_rs && w_rs_busy) || (bus.id_use_rt && w_rt_busy) ||
                     w_rd_busy || w_starved;

  regfile_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (w_issue),
    .i_set_addr (bus.id_rd),
    .i_clr_en   (w_xfer),
    .i_clr_addr (bus.lu_rw),
    .i_rs       (bus.id_rs),
    .i_rt       (bus.id_rt),
    .i_rd       (bus.id_rd),
    .o_rs_busy  (w_rs_busy),
    .o_rt_busy  (w_rt_busy),
    .o_rd_busy  (w_rd_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // Outputs are gated by rst_n so they sit at their idle values while reset is held.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    bus.rf_we      = 1'b0;
    bus.rf_rw      = '0;
    bus.rf_busw    = '0;
    bus.lu_ready   = 1'b0;
    bus.id_stall   = 1'b1;
    bus.init_done  = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_CLEAR: begin
          bus.rf_we      = 1'b1;
          bus.rf_rw      = r_clr_cnt;
          w_clr_cnt_next = r_clr_cnt + AW'(1);
          if (r_clr_cnt == AW'(NREG - 1)) begin
            w_state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          bus.init_done = 1'b1;
          bus.id_stall  = bus.id_valid && w_hazard;
          if (bus.wb_we) begin
            bus.rf_we   = (bus.wb_rw != REG_ZERO);
            bus.rf_rw   = bus.wb_rw;
            bus.rf_busw = bus.wb_data;
          end else if (bus.lu_valid) begin
            bus.lu_ready = 1'b1;
            bus.rf_we    = (bus.lu_rw != REG_ZERO);
            bus.rf_rw    = bus.lu_rw;
            bus.rf_busw  = bus.lu_data;
          end
        end
        default: begin
          w_state_next = ST_CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if ((r_state == ST_RUN) && bus.lu_valid && !bus.lu_ready) begin
      if (r_starve_cnt != 4'd15) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end else begin
      r_starve_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: sweep, arbitration, scoreboard, starvation, reset.
module tb_regfile_wb_scheduler;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  regfile_wb_scheduler_if bus ();

  regfile_wb_scheduler #(.STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.id_valid  = 1'b0;
    bus.id_rs     = '0;
    bus.id_rt     = '0;
    bus.id_use_rs = 1'b0;
    bus.id_use_rt = 1'b0;
    bus.id_rd     = '0;
    bus.id_long   = 1'b0;
    bus.wb_we     = 1'b0;
    bus.wb_rw     = '0;
    bus.wb_data   = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rw     = '0;
    bus.lu_data   = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rf_we"},     32'(bus.rf_we),     32'd0);
    check({tag, ".rf_rw"},     32'(bus.rf_rw),     32'd0);
    check({tag, ".rf_busw"},   bus.rf_busw,        32'd0);
    check({tag, ".id_stall"},  32'(bus.id_stall),  32'd1);
    check({tag, ".lu_ready"},  32'(bus.lu_ready),  32'd0);
    check({tag, ".init_done"}, 32'(bus.init_done), 32'd0);
  endtask

  // Called on a negedge with rst_n just released; leaves the bench one negedge into RUN.
  task automatic run_sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      #1;
      check($sformatf("%s.sweep%0d.we_rw_busw", tag, i),
            {bus.rf_we, bus.id_stall, bus.lu_ready, bus.init_done, 23'd0, bus.rf_rw} |
            (bus.rf_busw != 32'd0 ? 32'h0100_0000 : 32'd0),
            {1'b1, 1'b1, 1'b0, 1'b0, 23'd0, 5'(i)});
      step();
    end
    #1;
    check({tag, ".init_done"}, 32'(bus.init_done), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_n = 1'b0;
    bus.lu_valid = 1'b1;
    bus.wb_we    = 1'b1;
    bus.wb_rw    = 5'd7;
    repeat (2) step();
    #1;
    check_reset_outputs("reset");

    // 1: clear sweep with ID and both write sources requesting
    step();
    bus.id_valid = 1'b1;
    rst_n = 1'b1;
    run_sweep("sweep1");
    idle_inputs();
    #1;
    check("run.idle.rf_we",    32'(bus.rf_we),    32'd0);
    check("run.idle.id_stall", 32'(bus.id_stall), 32'd0);

    // 2: WB wins over the long unit, then the long result goes through
    step();
    bus.wb_we = 1'b1; bus.wb_rw = 5'd5; bus.wb_data = 32'hDEADBEEF;
    bus.lu_valid = 1'b1; bus.lu_rw = 5'd9; bus.lu_data = 32'h12345678;
    #1;
    check("arb.wb.rf_we",    32'(bus.rf_we),    32'd1);
    check("arb.wb.rf_rw",    32'(bus.rf_rw),    32'd5);
    check("arb.wb.rf_busw",  bus.rf_busw,       32'hDEADBEEF);
    check("arb.wb.lu_ready", 32'(bus.lu_ready), 32'd0);
    step();
    bus.wb_we = 1'b0;
    #1;
    check("arb.lu.lu_ready", 32'(bus.lu_ready), 32'd1);
    check("arb.lu.rf_we",    32'(bus.rf_we),    32'd1);
    check("arb.lu.rf_rw",    32'(bus.rf_rw),    32'd9);
    check("arb.lu.rf_busw",  bus.rf_busw,       32'h12345678);
    step();
    bus.lu_valid = 1'b0;

    // 3: long issue to r8, RAW and WAW stall, release after transfer
    bus.id_valid = 1'b1; bus.id_long = 1'b1; bus.id_rd = 5'd8;
    #1;
    check("sb.issue8.id_stall", 32'(bus.id_stall), 32'd0);
    step();
    bus.id_long = 1'b0; bus.id_rd = 5'd3; bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
    #1;
    check("sb.raw_rs.id_stall", 32'(bus.id_stall), 32'd1);
    bus.id_use_rs = 1'b0;
    #1;
    check("sb.rs_unused.id_stall", 32'(bus.id_stall), 32'd0);
    bus.id_rs = 5'd0; bus.id_rt = 5'd8; bus.id_use_rt = 1'b1;
    #1;
    check("sb.raw_rt.id_stall", 32'(bus.id_stall), 32'd1);
    bus.id_use_rt = 1'b0; bus.id_rd = 5'd8;
    #1;
    check("sb.waw.id_stall", 32'(bus.id_stall), 32'd1);
    bus.id_valid = 1'b0;
    #1;
    check("sb.novalid.id_stall", 32'(bus.id_stall), 32'd0);
    step();
    bus.id_valid = 1'b1; bus.id_rd = 5'd3; bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
    bus.lu_valid = 1'b1; bus.lu_rw = 5'd8; bus.lu_data = 32'hCAFE0008;
    #1;
    check("sb.xfer8.lu_ready",  32'(bus.lu_ready), 32'd1);
    check("sb.xfer8.id_stall",  32'(bus.id_stall), 32'd1);
    step();
    bus.lu_valid = 1'b0;
    #1;
    check("sb.after8.id_stall", 32'(bus.id_stall), 32'd0);
    step();

    // 4: starvation throttles issue from the fifth blocked cycle
    bus.id_rs = 5'd0; bus.id_use_rs = 1'b0; bus.id_rd = 5'd2; bus.id_long = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rw = 5'd4; bus.wb_data = 32'h44;
    bus.lu_valid = 1'b1; bus.lu_rw = 5'd10; bus.lu_data = 32'hA0;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("starve.blk%0d.id_stall", k), 32'(bus.id_stall), (k >= 5) ? 32'd1 : 32'd0);
      step();
    end
    bus.wb_we = 1'b0;
    #1;
    check("starve.xfer.lu_ready", 32'(bus.lu_ready), 32'd1);
    check("starve.xfer.id_stall", 32'(bus.id_stall), 32'd1);
    step();
    bus.lu_valid = 1'b0;
    #1;
    check("starve.clear.id_stall", 32'(bus.id_stall), 32'd0);
    step();

    // 5: writes aimed at r0 never reach the register file
    bus.id_valid = 1'b0;
    bus.wb_we = 1'b1; bus.wb_rw = 5'd0; bus.wb_data = 32'hFFFFFFFF;
    #1;
    check("r0.wb.rf_we", 32'(bus.rf_we), 32'd0);
    step();
    bus.wb_we = 1'b0;
    bus.lu_valid = 1'b1; bus.lu_rw = 5'd0; bus.lu_data = 32'h55;
    #1;
    check("r0.lu.rf_we",    32'(bus.rf_we),    32'd0);
    check("r0.lu.lu_ready", 32'(bus.lu_ready), 32'd1);
    step();
    bus.lu_valid = 1'b0;

    // 6: reset mid-RUN with r8 busy, sweep restarts and scoreboard is empty
    bus.id_valid = 1'b1; bus.id_long = 1'b1; bus.id_rd = 5'd8;
    #1;
    check("rst.issue8.id_stall", 32'(bus.id_stall), 32'd0);
    step();
    bus.id_long = 1'b0;
    #1;
    check("rst.busy8.id_stall", 32'(bus.id_stall), 32'd1);
    bus.wb_we = 1'b1; bus.wb_rw = 5'd6; bus.lu_valid = 1'b1; bus.lu_rw = 5'd8;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    step();
    rst_n = 1'b1;
    run_sweep("sweep2");
    idle_inputs();
    bus.id_valid = 1'b1; bus.id_rd = 5'd8; bus.id_rs = 5'd8; bus.id_use_rs = 1'b1;
    #1;
    check("rst.after.id_stall", 32'(bus.id_stall), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
